// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD subtractor.
// Holds the digit type, FSM state encoding and radix constants.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_t BCD_MAX   = 4'd9;
    localparam bcd_t BCD_RADIX = 4'd10;

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract step: a - b - borrow_in.
// Negative results wrap by adding the radix and raise borrow_out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_t i_a,
    input  bcd_t i_b,
    input  logic i_bin,
    output bcd_t o_d,
    output logic o_bout
);

    logic [4:0] w_t;

    assign w_t    = {1'b0, i_a} - {1'b0, i_b} - {4'b0, i_bin};
    assign o_bout = w_t[4];
    assign o_d    = o_bout ? (w_t[3:0] + BCD_RADIX) : w_t[3:0];

endmodule

// File: rtl/bcd_sub_serial.sv
// Serial packed-BCD subtractor, one digit per clock, LSD first.
// Digit 0 is resolved on the start edge so a result lands every NDIG+1 cycles.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] x,
    input  logic [4*NDIG-1:0] y,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] diff,
    output logic              bout,
    output logic              invalid
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_diff;
    logic [W-1:0]    w_acc;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx;
    logic            r_borrow;
    logic            r_bout;
    logic            r_invalid;
    logic            w_bad;
    logic            w_go;
    logic            w_step;
    logic            w_last;
    logic            w_bin;
    logic            w_bo;
    bcd_t            w_a;
    bcd_t            w_b;
    bcd_t            w_d;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (x[4*i +: 4] > BCD_MAX || y[4*i +: 4] > BCD_MAX)
                w_bad = 1'b1;
        end
    end

    // In IDLE the step unit sees the live inputs so digit 0 is done on the start edge
    always_comb begin
        w_idx = r_idx;
        w_a   = r_x[4*int'(r_idx) +: 4];
        w_b   = r_y[4*int'(r_idx) +: 4];
        w_bin = r_borrow;
        if (r_state == IDLE) begin
            w_idx = '0;
            w_a   = x[3:0];
            w_b   = y[3:0];
            w_bin = bin;
        end
    end

    bcd_digit_sub u_step (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_bin  (w_bin),
        .o_d    (w_d),
        .o_bout (w_bo)
    );

    always_comb begin
        w_acc = (r_state == IDLE) ? '0 : r_acc;
        w_acc[4*int'(w_idx) +: 4] = w_d;
    end

    assign w_go   = (r_state == IDLE) && start && !w_bad;
    assign w_step = w_go || (r_state == CALC);
    assign w_last = (w_idx == IW'(NDIG - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start)
                    w_next = (w_bad || w_last) ? DONE : CALC;
            end
            CALC: begin
                if (w_last)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_diff    <= '0;
            r_idx     <= '0;
            r_borrow  <= 1'b0;
            r_bout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_x       <= x;
                r_y       <= y;
                r_invalid <= w_bad;
            end
            if (w_step) begin
                r_acc    <= w_acc;
                r_borrow <= w_bo;
                r_idx    <= w_idx + IW'(1);
            end
            if (r_state == IDLE && start && w_bad) begin
                r_diff <= '0;
                r_bout <= 1'b0;
            end else if (w_step && w_last) begin
                r_diff <= w_acc;
                r_bout <= w_bo;
            end
        end
    end

    assign busy    = (r_state == CALC);
    assign done    = (r_state == DONE);
    assign diff    = r_diff;
    assign bout    = r_bout;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed plus random checks of bcd_sub_serial against a decimal model.
// Reference works on plain integers, not digit-serial steps.
module tb_bcd_sub_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        invalid;

    int          n_chk;
    int          n_err;
    logic [15:0] prev_diff;

    bcd_sub_serial #(.NDIG(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
        .y       (y),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_bad(input logic [15:0] v);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (d > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         input logic bi, output logic [15:0] ed,
                         output logic eb, output logic ei, output int el);
        int d;
        if (has_bad(a) || has_bad(b)) begin
            ed = 16'h0; eb = 1'b0; ei = 1'b1; el = 1;
        end else begin
            d  = bcd2int(a) - bcd2int(b) - int'(bi);
            eb = (d < 0);
            if (d < 0) d += 10000;
            ed = int2bcd(d); ei = 1'b0; el = 4;
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input bit glitch);
        logic [15:0] ed;
        logic        eb;
        logic        ei;
        int          el;
        int          lat;
        model(a, b, bi, ed, eb, ei, el);
        @(negedge clk);
        x = a; y = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (lat == 2) chk("diff_frozen_in_calc", diff, prev_diff);
            if (glitch && lat == 2) begin
                start = 1'b1; x = 16'h9999; y = 16'h0000; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, el);
        chk("busy_at_done", busy, 0);
        chk("diff", diff, ed);
        chk("bout", bout, eb);
        chk("invalid", invalid, ei);
        prev_diff = ed;
        @(posedge clk); #1;
        chk("done_single", done, 0);
        chk("diff_hold", diff, ed);
        chk("bout_hold", bout, eb);
    endtask

    initial begin
        logic [15:0] ca;
        logic [15:0] cb;
        logic        cbi;
        logic [15:0] ed;
        logic        eb;
        logic        ei;
        int          el;

        n_chk = 0; n_err = 0; prev_diff = 16'h0;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_invalid", invalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h5432, 16'h1234, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
        run_op(16'h1000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        run_op(16'h5432, 16'h1234, 1'b0, 1'b1);

        for (int k = 0; k < 10; k++)
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 2; k++) begin
            ca = rand_bcd();
            ca[4*(k+1) +: 4] = 4'($urandom_range(10, 15));
            run_op(rand_bcd(), ca, 1'b0, 1'b0);
        end

        run_op(16'h5432, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        x = 16'h5432; y = 16'h1234; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        chk("midrst_invalid", invalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
        end
        prev_diff = 16'h0;
        run_op(16'h9999, 16'h9999, 1'b0, 1'b0);

        ca = rand_bcd(); cb = rand_bcd(); cbi = 1'($urandom_range(0, 1));
        @(negedge clk);
        x = ca; y = cb; bin = cbi; start = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            chk("stream_done", done, ((c % 5) == 3));
            chk("stream_busy", busy, ((c % 5) < 3));
            if ((c % 5) == 3) begin
                model(ca, cb, cbi, ed, eb, ei, el);
                chk("stream_diff", diff, ed);
                chk("stream_bout", bout, eb);
                ca = rand_bcd(); cb = rand_bcd();
                cbi = 1'($urandom_range(0, 1));
                x = ca; y = cb; bin = cbi;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand (NDIG >= 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin one subtraction, sampled on a rising clk edge.
REQ-005 SHALL have port x  input  4*NDIG  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port y  input  4*NDIG  subtrahend, packed BCD, same packing as x.
REQ-007 SHALL have port bin  input  1  borrow-in, weight 1 at digit 0.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port diff  output  4*NDIG  packed BCD difference.
REQ-011 SHALL have port bout  output  1  borrow-out; high when x < y + bin.
REQ-012 SHALL have port invalid  output  1  high when any latched operand digit exceeds 9.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 SHALL latch x, y and bin, clear the digit index and the running borrow to bin, and select the next state.
REQ-015 If any latched digit of x or y is greater than 9, the next state SHALL be DONE, with invalid=1, diff=0 and bout=0.
REQ-016 Otherwise the next state SHALL be CALC, and busy SHALL be 1 from that edge onward.
REQ-017 In CALC, each edge SHALL process one digit, LSD first: t = x_i - y_i - borrow.
REQ-018 If t < 0, then diff_i = t + 10 and borrow = 1; otherwise diff_i = t and borrow = 0.
REQ-019 After digit NDIG-1 is processed, the state SHALL move to DONE with bout equal to the final borrow.
REQ-020 Valid-operand latency SHALL be NDIG edges from the start-sampling edge to the edge asserting done.
REQ-021 Invalid-operand latency SHALL be 1 edge.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the state SHALL return to IDLE on the next edge.
REQ-023 diff, bout and invalid SHALL hold their values until the next accepted start.
REQ-024 diff SHALL only be updated digit-by-digit internally; the diff port SHALL change only on the edge entering DONE.
REQ-025 start while busy=1 or in DONE SHALL be ignored and SHALL NOT alter the latched operands.
REQ-026 A start asserted during the IDLE cycle right after DONE SHALL be accepted, giving back-to-back throughput of one result per NDIG+1 cycles.
REQ-027 On underflow, diff SHALL be the tens-complement result (10^NDIG + x - y - bin), with bout=1.
REQ-028 Every diff digit SHALL be in the range 0..9 whenever invalid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, diff=0, bout=0, invalid=0, digit index 0, running borrow 0.
REQ-030 Reset asserted mid-CALC SHALL abandon the operation with no done pulse.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n=1.

Structure
REQ-032 A shared package bcd_pkg SHALL hold the 4-bit BCD digit type, the FSM state enum, and the constants BCD_MAX=9 and BCD_RADIX=10.
REQ-033 The one-digit combinational step (digit, digit, borrow-in -> digit, borrow-out) SHALL be a sub-module bcd_digit_sub, instantiated once and reused every CALC cycle.
REQ-034 The digit index counter SHALL be sized $clog2(NDIG), with a minimum width of 1.

Verification (NDIG=4)
REQ-035 x=0x5432, y=0x1234, bin=0 -> done 4 edges after start, diff=0x4198, bout=0, invalid=0.
REQ-036 x=0x0000, y=0x0001, bin=0 -> diff=0x9999, bout=1; also x=0x1000, y=0x0000, bin=1 -> diff=0x0999, bout=0.
REQ-037 x=0x12A4, y=0x0001 -> done 1 edge after start, invalid=1, diff=0x0000, bout=0.
REQ-038 start pulsed again 2 cycles into CALC with different operands -> ignored; first result 0x4198 delivered unchanged.
REQ-039 rst_n pulled low during the 3rd CALC cycle -> all outputs 0 immediately, no done pulse; a following start with 0x9999-0x9999 -> diff=0x0000, bout=0.
REQ-040 Start held high continuously -> one done every 5 cycles, each diff correct, busy never high in the same cycle as done.
